mux2_stream_arbiter: RTL and testbench

- Sequential front-end for the 2:1 mux stage. Arbitrates between two valid/ready input streams and drives the mux select from the grant.
- Registers the selected beat into a one-entry output stage that feeds the downstream consumer.
- Supports round-robin or fixed-priority arbitration. Each output beat carries the index of the source it came from.

---
 rtl/mux2_stream_arbiter.sv | 68 ++++++
 tb/tb_mux2_stream_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux2_stream_arbiter.sv
// Two-input valid/ready arbiter feeding a one-entry registered output stage.
// Round-robin or fixed-priority (A wins) grant; each output beat is tagged with its source.
module mux2_stream_arbiter #(
    parameter int WIDTH       = 8,
    parameter int ROUND_ROBIN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready
);

    logic             load_en;
    logic             grant_any;
    logic             sel;
    logic             last_src;
    logic             accept;
    logic [WIDTH-1:0] mux_data;

    assign load_en = !out_valid || out_ready;

    // sel picks the source (0 = A, 1 = B); only meaningful when grant_any is high.
    always_comb begin
        grant_any = 1'b0;
        sel       = 1'b0;
        if (a_valid && b_valid) begin
            grant_any = 1'b1;
            sel       = (ROUND_ROBIN != 0) ? !last_src : 1'b0;
        end else if (a_valid) begin
            grant_any = 1'b1;
            sel       = 1'b0;
        end else if (b_valid) begin
            grant_any = 1'b1;
            sel       = 1'b1;
        end
    end

    // Readies are forced low during reset even though the empty output stage would otherwise allow a load.
    assign a_ready  = rst_n && load_en && grant_any && !sel;
    assign b_ready  = rst_n && load_en && grant_any && sel;
    assign accept   = load_en && grant_any;
    assign mux_data = sel ? b_data : a_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
            last_src  <= 1'b1;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= mux_data;
            out_src   <= sel;
            last_src  <= sel;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux2_stream_arbiter.sv
// Scoreboard bench: a round-robin and a fixed-priority instance share stimulus; valids are steered by mode.
module tb_mux2_stream_arbiter;

    logic       clk;
    logic       rst_n;
    logic       mode;
    logic       a_valid, b_valid;
    logic [7:0] a_data, b_data;
    logic       out_ready;

    logic       a_valid_rr, b_valid_rr, a_ready_rr, b_ready_rr, out_valid_rr, out_src_rr;
    logic [7:0] out_data_rr;
    logic       a_valid_fp, b_valid_fp, a_ready_fp, b_ready_fp, out_valid_fp, out_src_fp;
    logic [7:0] out_data_fp;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int c0;

    logic [8:0] rr_q[$];
    logic [8:0] fp_q[$];

    assign a_valid_rr = a_valid && !mode;
    assign b_valid_rr = b_valid && !mode;
    assign a_valid_fp = a_valid && mode;
    assign b_valid_fp = b_valid && mode;

    mux2_stream_arbiter #(.WIDTH(8), .ROUND_ROBIN(1)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid_rr), .a_data(a_data), .a_ready(a_ready_rr),
        .b_valid(b_valid_rr), .b_data(b_data), .b_ready(b_ready_rr),
        .out_valid(out_valid_rr), .out_data(out_data_rr), .out_src(out_src_rr),
        .out_ready(out_ready)
    );

    mux2_stream_arbiter #(.WIDTH(8), .ROUND_ROBIN(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid_fp), .a_data(a_data), .a_ready(a_ready_fp),
        .b_valid(b_valid_fp), .b_data(b_data), .b_ready(b_ready_fp),
        .out_valid(out_valid_fp), .out_data(out_data_fp), .out_src(out_src_fp),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drives n consecutive beats starting at first on one source, holding each until accepted.
    task automatic applyStimulus(input bit src, input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            int  guard;
            logic rdy;
            guard = 0;
            if (src) begin b_valid = 1'b1; b_data = first + 8'(i); end
            else     begin a_valid = 1'b1; a_data = first + 8'(i); end
            do begin
                @(negedge clk);
                guard++;
                rdy = src ? (mode ? b_ready_fp : b_ready_rr) : (mode ? a_ready_fp : a_ready_rr);
            end while (!rdy && guard < 50);
            if (!rdy) begin
                tests++;
                fails++;
                $display("[TB] FAIL accept_timeout src=%0d: beat %0h never accepted", src, first + 8'(i));
            end
            @(posedge clk); #1;
        end
        if (src) b_valid = 1'b0;
        else     a_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        out_ready = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid_rr && out_ready) begin
            if (rr_q.size() == 0) begin
                tests++; fails++;
                $display("[TB] FAIL rr_unexpected: got beat %0h src %0d, expected none", out_data_rr, out_src_rr);
            end else begin
                logic [8:0] e;
                e = rr_q.pop_front();
                checkOutput("rr_data", 32'(out_data_rr), 32'(e[7:0]));
                checkOutput("rr_src", 32'(out_src_rr), 32'(e[8]));
            end
        end
        if (rst_n && out_valid_fp && out_ready) begin
            if (fp_q.size() == 0) begin
                tests++; fails++;
                $display("[TB] FAIL fp_unexpected: got beat %0h src %0d, expected none", out_data_fp, out_src_fp);
            end else begin
                logic [8:0] e;
                e = fp_q.pop_front();
                checkOutput("fp_data", 32'(out_data_fp), 32'(e[7:0]));
                checkOutput("fp_src", 32'(out_src_fp), 32'(e[8]));
            end
        end
        if (rst_n && mode && a_valid)
            checkOutput("fp_b_ready_blocked", 32'(b_ready_fp), 32'd0);
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; mode = 1'b0; out_ready = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1; a_data = 8'hAA; b_data = 8'hBB;
        #12;
        checkOutput("reset_out_valid", 32'(out_valid_rr), 32'd0);
        checkOutput("reset_out_data", 32'(out_data_rr), 32'd0);
        checkOutput("reset_out_src", 32'(out_src_rr), 32'd0);
        checkOutput("reset_a_ready", 32'(a_ready_rr), 32'd0);
        checkOutput("reset_b_ready", 32'(b_ready_rr), 32'd0);
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset mid-stream: park 5A in the output, then assert reset between edges.
        applyStimulus(0, 8'h5A, 1);
        checkOutput("pre_reset_valid", 32'(out_valid_rr), 32'd1);
        checkOutput("pre_reset_data", 32'(out_data_rr), 32'h5A);
        a_valid = 1'b1; a_data = 8'h77;
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_out_valid", 32'(out_valid_rr), 32'd0);
        checkOutput("midreset_out_data", 32'(out_data_rr), 32'd0);
        checkOutput("midreset_a_ready", 32'(a_ready_rr), 32'd0);
        a_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Round-robin contention straight after reset: A first, then strict alternation.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rr_q.push_back({1'b0, 8'h10 + 8'(i)});
            rr_q.push_back({1'b1, 8'h20 + 8'(i)});
        end
        c0 = cyc;
        fork
            applyStimulus(0, 8'h10, 4);
            applyStimulus(1, 8'h20, 4);
        join
        checkOutput("rr_throughput_cycles", 32'(cyc - c0), 32'd8);
        idle(2);

        // Backpressure: 33 stalls for 3 cycles, then 34 loads the cycle out_ready returns.
        out_ready = 1'b0;
        a_valid = 1'b1; a_data = 8'h33;
        rr_q.push_back({1'b0, 8'h33});
        @(posedge clk); #1;
        a_data = 8'h34;
        rr_q.push_back({1'b0, 8'h34});
        repeat (3) begin
            @(negedge clk);
            checkOutput("stall_out_valid", 32'(out_valid_rr), 32'd1);
            checkOutput("stall_out_data", 32'(out_data_rr), 32'h33);
            checkOutput("stall_a_ready", 32'(a_ready_rr), 32'd0);
            checkOutput("stall_b_ready", 32'(b_ready_rr), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("unstall_a_ready", 32'(a_ready_rr), 32'd1);
        @(posedge clk); #1;
        a_valid = 1'b0;
        checkOutput("no_bubble_valid", 32'(out_valid_rr), 32'd1);
        checkOutput("no_bubble_data", 32'(out_data_rr), 32'h34);
        idle(2);

        // Only B, then contention next cycle goes to A because B was last.
        rr_q.push_back({1'b1, 8'hC1});
        rr_q.push_back({1'b1, 8'hC2});
        applyStimulus(1, 8'hC1, 2);
        rr_q.push_back({1'b0, 8'h40});
        rr_q.push_back({1'b1, 8'h50});
        fork
            applyStimulus(0, 8'h40, 1);
            applyStimulus(1, 8'h50, 1);
        join
        idle(2);

        // Idle gap after an A beat: output empties, and the next contention grants B.
        rr_q.push_back({1'b0, 8'h55});
        applyStimulus(0, 8'h55, 1);
        idle(2);
        checkOutput("idle_out_valid", 32'(out_valid_rr), 32'd0);
        rr_q.push_back({1'b1, 8'h70});
        rr_q.push_back({1'b0, 8'h60});
        fork
            applyStimulus(0, 8'h60, 1);
            applyStimulus(1, 8'h70, 1);
        join
        idle(2);

        // Fixed priority: A drains completely before B is served.
        mode = 1'b1;
        for (int i = 0; i < 4; i++) fp_q.push_back({1'b0, 8'h10 + 8'(i)});
        for (int i = 0; i < 4; i++) fp_q.push_back({1'b1, 8'h20 + 8'(i)});
        c0 = cyc;
        fork
            applyStimulus(0, 8'h10, 4);
            applyStimulus(1, 8'h20, 4);
        join
        checkOutput("fp_throughput_cycles", 32'(cyc - c0), 32'd8);
        idle(3);

        checkOutput("rr_queue_empty", 32'(rr_q.size()), 32'd0);
        checkOutput("fp_queue_empty", 32'(fp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
